// File: rtl/l1d_cache_wb.sv
// l1d_cache_wb: set-associative L1 data cache, write-back / write-allocate.
// Sits between the load/store unit and main memory. Hits complete locally in
// two cycles; a miss writes back a dirty victim line, then burst-fills the
// requested line. Victim choice: lowest invalid way first, otherwise a per-set
// FIFO pointer (REPL_MODE=0) or true LRU ages (REPL_MODE=1).
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   REQ, WE, ADDR, WDATA     CPU request (sampled in IDLE only)
//   RDATA, RESP, BUSY        load data, one-cycle completion pulse, busy flag
//   MEM_VALID, MEM_READY     memory command handshake
//   MEM_WE, MEM_ADDR         1 = write-back / 0 = fill, line-aligned address
//   MEM_WDATA, MEM_WREADY    write-back beat data and beat consume strobe
//   MEM_RDATA, MEM_RVALID    fill beat data and valid (no backpressure)
module l1d_cache_wb #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WAYS           = 4,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int REPL_MODE      = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              RESP,
  output logic              BUSY,
  output logic              MEM_VALID,
  input  logic              MEM_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_WREADY,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_RVALID
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int ARR_W = IDX_W + WAY_W + OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [WAY_W-1:0] MAX_AGE   = WAY_W'(WAYS - 1);

  typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RESPOND, S_WB_CMD, S_WB_DATA, S_FILL_CMD, S_FILL_DATA
  } state_t;

  // Age 0 = most recent. Ways not older than the touched one age by one
  // (saturating), so ages become a permutation once the set has filled up.
  function automatic age_vec_t lru_touch(input age_vec_t a, input logic [WAY_W-1:0] w);
    age_vec_t r;
    r = a;
    for (int v = 0; v < WAYS; v++) begin
      if (WAY_W'(v) == w)
        r[v] = '0;
      else if (a[v] <= a[w] && a[v] != MAX_AGE)
        r[v] = a[v] + 1'b1;
    end
    return r;
  endfunction

  state_t state, state_nx;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;

  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_off = req_addr[OFF_W-1:0];

  logic [DATA_W-1:0] data_arr [SETS*WAYS*WORDS_PER_LINE];
  logic [TAG_W-1:0]  tag_arr  [SETS][WAYS];
  logic [WAYS-1:0]   valid_arr [SETS];
  logic [WAYS-1:0]   dirty_arr [SETS];
  logic [WAY_W-1:0]  fifo_ptr  [SETS];
  age_vec_t          age_arr   [SETS];

  logic              hit, inv_found;
  logic [WAY_W-1:0]  hit_way, inv_way, lru_way, victim, vic_way;
  logic [OFF_W-1:0]  beat;
  logic [DATA_W-1:0] rdata_q;

  logic              arr_we;
  logic [ARR_W-1:0]  arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  assign RDATA = rdata_q;

  // Tag compare and victim choice for the captured request's set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Scanning downward leaves the lowest-index invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    for (int w = 1; w < WAYS; w++) begin
      if (age_arr[req_idx][w] > age_arr[req_idx][lru_way])
        lru_way = WAY_W'(w);
    end
    if (inv_found)
      victim = inv_way;
    else if (REPL_MODE == 1)
      victim = lru_way;
    else
      victim = fifo_ptr[req_idx];
  end

  // Next-state and outputs
  always_comb begin
    state_nx  = state;
    RESP      = 1'b0;
    BUSY      = 1'b1;
    MEM_VALID = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    arr_we    = 1'b0;
    arr_waddr = '0;
    arr_wdata = '0;
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (REQ) state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          state_nx = S_RESPOND;
          if (req_we) begin
            arr_we    = 1'b1;
            arr_waddr = {req_idx, hit_way, req_off};
            arr_wdata = req_wdata;
          end
        end else if (valid_arr[req_idx][victim] && dirty_arr[req_idx][victim]) begin
          state_nx = S_WB_CMD;
        end else begin
          state_nx = S_FILL_CMD;
        end
      end
      S_WB_CMD: begin
        MEM_VALID = 1'b1;
        MEM_WE    = 1'b1;
        MEM_ADDR  = {tag_arr[req_idx][vic_way], req_idx, {OFF_W{1'b0}}};
        if (MEM_READY) state_nx = S_WB_DATA;
      end
      S_WB_DATA: begin
        MEM_WDATA = data_arr[{req_idx, vic_way, beat}];
        if (MEM_WREADY && beat == LAST_BEAT) state_nx = S_FILL_CMD;
      end
      S_FILL_CMD: begin
        MEM_VALID = 1'b1;
        MEM_ADDR  = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (MEM_READY) state_nx = S_FILL_DATA;
      end
      S_FILL_DATA: begin
        if (MEM_RVALID) begin
          arr_we    = 1'b1;
          arr_waddr = {req_idx, vic_way, beat};
          // Store miss: the store word replaces the fetched word in flight.
          arr_wdata = (req_we && beat == req_off) ? req_wdata : MEM_RDATA;
          if (beat == LAST_BEAT) state_nx = S_RESPOND;
        end
      end
      S_RESPOND: begin
        RESP     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Control state: FSM, beat counter, load data, per-set metadata
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      beat    <= '0;
      rdata_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        fifo_ptr[s]  <= '0;
        age_arr[s]   <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        S_LOOKUP: begin
          beat <= '0;
          if (hit) begin
            age_arr[req_idx] <= lru_touch(age_arr[req_idx], hit_way);
            if (req_we)
              dirty_arr[req_idx][hit_way] <= 1'b1;
            else
              rdata_q <= data_arr[{req_idx, hit_way, req_off}];
          end
        end
        S_WB_DATA: begin
          if (MEM_WREADY) beat <= beat + 1'b1;
        end
        S_FILL_DATA: begin
          if (MEM_RVALID) begin
            beat <= beat + 1'b1;
            if (!req_we && beat == req_off) rdata_q <= MEM_RDATA;
            if (beat == LAST_BEAT) begin
              valid_arr[req_idx][vic_way] <= 1'b1;
              dirty_arr[req_idx][vic_way] <= req_we;
              fifo_ptr[req_idx]           <= fifo_ptr[req_idx] + 1'b1;
              age_arr[req_idx]            <= lru_touch(age_arr[req_idx], vic_way);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: request capture, victim latch, tag and data arrays
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && REQ) begin
      req_we    <= WE;
      req_addr  <= ADDR;
      req_wdata <= WDATA;
    end
    if (state == S_LOOKUP) vic_way <= victim;
    if (arr_we) data_arr[arr_waddr] <= arr_wdata;
    if (state == S_FILL_DATA && MEM_RVALID && beat == LAST_BEAT)
      tag_arr[req_idx][vic_way] <= req_tag;
  end

endmodule
